// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: load wait FSM, load alignment, register file write port, instret
module wb_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [4:0]  i_rd,
    input  logic        i_is_load,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_res,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_dat,
    output logic        o_stall,
    output logic        o_pend_valid,
    output logic [4:0]  o_pend_rd,
    output logic        o_we,
    output logic [4:0]  o_addr_wr,
    output logic [31:0] o_dat_wr,
    output logic [63:0] o_instret
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic [4:0]  cap_rd;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_addr_lo;
    logic        capture;
    logic        retire;
    logic [4:0]  ret_rd;
    logic [31:0] ret_dat;

    function automatic logic [31:0] align_load(input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr_lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        // addr_lo[0] is deliberately ignored for halfwords
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  align_load = {{24{b[7]}}, b};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b100:  align_load = {24'd0, b};
            3'b101:  align_load = {16'd0, h};
            default: align_load = word;
        endcase
    endfunction

    assign o_stall      = (state == S_WAIT);
    assign o_pend_valid = (state == S_WAIT);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        retire    = 1'b0;
        ret_rd    = i_rd;
        ret_dat   = i_alu_res;
        if (state == S_IDLE) begin
            if (i_valid) begin
                if (!i_is_load) begin
                    retire = 1'b1;
                end else if (i_mem_ack) begin
                    retire  = 1'b1;
                    ret_dat = align_load(i_funct3, i_alu_res[1:0], i_mem_dat);
                end else begin
                    capture   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
        end else begin
            // i_valid is ignored here; upstream is held by o_stall
            if (i_mem_ack) begin
                retire    = 1'b1;
                ret_rd    = cap_rd;
                ret_dat   = align_load(cap_funct3, cap_addr_lo, i_mem_dat);
                state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cap_rd      <= 5'd0;
            cap_funct3  <= 3'd0;
            cap_addr_lo <= 2'd0;
            o_pend_rd   <= 5'd0;
            o_we        <= 1'b0;
            o_addr_wr   <= 5'd0;
            o_dat_wr    <= 32'd0;
            o_instret   <= 64'd0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cap_rd      <= i_rd;
                cap_funct3  <= i_funct3;
                cap_addr_lo <= i_alu_res[1:0];
                o_pend_rd   <= i_rd;
            end
            o_we <= retire && (ret_rd != 5'd0);
            if (retire) begin
                // x0 retires normally but never presents a visible write
                o_addr_wr <= (ret_rd != 5'd0) ? ret_rd : 5'd0;
                o_dat_wr  <= (ret_rd != 5'd0) ? ret_dat : 32'd0;
                o_instret <= o_instret + 64'd1;
            end
        end
    end

endmodule
